memory_port_arbiter: RTL

//  Shares one single-ported 64-bit memory between the processor's instruction-fetch

---
 rtl/memory_port_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: round-robin sharing of one fixed-latency 64-bit memory
// between instruction fetch and data load/store, one access at a time.
module memory_port_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [63:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [63:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata,
    output logic              busy
);
    localparam logic S_IDLE   = 1'b0;
    localparam logic S_ACCESS = 1'b1;
    localparam int   CW       = $clog2(MEM_LATENCY + 1);

    logic              state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              win_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       wdata_q;
    logic              if_gnt_q, d_gnt_q, if_valid_q, d_valid_q;
    logic [31:0]       if_rdata_q;
    logic [63:0]       d_rdata_q;
    logic              accept, done, pick_d;

    // win_q doubles as last_grant: 1 = data path won most recently
    always_comb begin
        pick_d  = d_req & (~if_req | ~win_q);
        accept  = (state_q == S_IDLE) & (if_req | d_req);
        done    = (state_q == S_ACCESS) & (cnt_q == CW'(1));
        state_d = accept ? S_ACCESS : done ? S_IDLE : state_q;
        cnt_d   = accept ? CW'(MEM_LATENCY) : (state_q == S_ACCESS) ? cnt_q - CW'(1) : cnt_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            win_q      <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_gnt_q   <= 1'b0;
            d_gnt_q    <= 1'b0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            if_gnt_q   <= accept & ~pick_d;
            d_gnt_q    <= accept & pick_d;
            if_valid_q <= done & ~win_q;
            d_valid_q  <= done & win_q;
            if (accept) begin
                win_q   <= pick_d;
                we_q    <= pick_d & d_we;
                addr_q  <= pick_d ? d_addr : if_addr;
                wdata_q <= pick_d ? d_wdata : '0;
            end
            if (done & ~win_q)
                if_rdata_q <= addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
            if (done & win_q & ~we_q)
                d_rdata_q <= mem_rdata;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign if_valid  = if_valid_q;
    assign d_valid   = d_valid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = state_q;
    assign mem_we    = state_q & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = state_q;
endmodule
